// File: rtl/vga_layer_mixer_if.sv
// Pixel bus between the VGA sync driver and the layer mixer.
// Latency: none, wires only.
// Backpressure: none; the pixel stream advances every mclk.
//
// Ports (as seen by the mixer, slave modport):
//   in  hsync_in, vsync_in, von_in, frame_tick, blink_req
//   in  layer_color[N_LAYERS*COLOR_W], layer_valid[N_LAYERS], layer_en[N_LAYERS]
//   out color_out[COLOR_W], hsync_out, vsync_out, von_out, blink_phase
interface vga_layer_mixer_if #(
  parameter int N_LAYERS = 4,
  parameter int COLOR_W  = 8
);
  logic                         hsync_in;
  logic                         vsync_in;
  logic                         von_in;
  logic                         frame_tick;
  logic [N_LAYERS*COLOR_W-1:0]  layer_color;
  logic [N_LAYERS-1:0]          layer_valid;
  logic [N_LAYERS-1:0]          layer_en;
  logic                         blink_req;
  logic [COLOR_W-1:0]           color_out;
  logic                         hsync_out;
  logic                         vsync_out;
  logic                         von_out;
  logic                         blink_phase;

  modport master (
    output hsync_in, vsync_in, von_in, frame_tick, layer_color, layer_valid,
           layer_en, blink_req,
    input  color_out, hsync_out, vsync_out, von_out, blink_phase
  );

  modport slave (
    input  hsync_in, vsync_in, von_in, frame_tick, layer_color, layer_valid,
           layer_en, blink_req,
    output color_out, hsync_out, vsync_out, von_out, blink_phase
  );
endinterface

// File: rtl/vga_layer_mixer.sv
// Priority compositor of N_LAYERS colour sources over a background, with blanking and blink.
// Latency: PIPE mclk cycles from bus inputs to color_out/hsync_out/vsync_out/von_out.
// Backpressure: none; one pixel accepted and produced every mclk.
//
// Ports:
//   mclk   system clock
//   reset  synchronous, active-high
//   bus    vga_layer_mixer_if slave (sync/visible/tick/layer inputs, composited outputs)
module vga_layer_mixer #(
  parameter int                  N_LAYERS     = 4,
  parameter int                  COLOR_W      = 8,
  parameter int                  PIPE         = 2,
  parameter logic [COLOR_W-1:0]  BG_COLOR     = 8'b010_010_01,
  parameter logic [N_LAYERS-1:0] BLINK_MASK   = '1,
  parameter int                  BLINK_FRAMES = 15,
  parameter logic                SYNC_IDLE    = 1'b1
) (
  input logic             mclk,
  input logic             reset,
  vga_layer_mixer_if.slave bus
);

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic               hsync;
    logic               vsync;
    logic               von;
  } stage_t;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } phase_e;

  localparam stage_t     STAGE_IDLE = '{color: '0, hsync: SYNC_IDLE, vsync: SYNC_IDLE, von: 1'b0};
  localparam logic [7:0] CNT_LAST   = 8'(BLINK_FRAMES - 1);

  logic [N_LAYERS-1:0] en_q;
  phase_e              phase_q, phase_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [N_LAYERS-1:0] eff;
  logic [COLOR_W-1:0]  sel_color;
  stage_t              stage_in;
  stage_t              stage_tail;
  stage_t              pipe_q [PIPE];

  // Enables only move on the frame boundary so a frame is never torn.
  always_ff @(posedge mclk) begin
    if (reset) begin
      en_q <= '1;
    end else if (bus.frame_tick) begin
      en_q <= bus.layer_en;
    end
  end

  // Blink state machine: cnt counts frame ticks within a half-period.
  always_ff @(posedge mclk) begin
    if (reset) begin
      phase_q <= ON;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (!bus.blink_req) begin
      // Dropping the request wins over a coincident tick.
      phase_d = ON;
      cnt_d   = '0;
    end else if (bus.frame_tick) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        phase_d = (phase_q == ON) ? OFF : ON;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Stage 1 select: lowest-index effective layer wins, walk from lowest priority up.
  assign eff = bus.layer_valid & en_q & ~(BLINK_MASK & {N_LAYERS{phase_q == OFF}});

  always_comb begin
    sel_color = BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) begin
        sel_color = bus.layer_color[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_comb begin
    stage_in       = STAGE_IDLE;
    stage_in.color = sel_color;
    stage_in.hsync = bus.hsync_in;
    stage_in.vsync = bus.vsync_in;
    stage_in.von   = bus.von_in;
  end

  // Blanking is applied on entry to the last stage so color_out stays registered.
  always_comb begin
    stage_tail = pipe_q[PIPE-2];
    if (!stage_tail.von) begin
      stage_tail.color = '0;
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      for (int k = 0; k < PIPE; k++) begin
        pipe_q[k] <= STAGE_IDLE;
      end
    end else begin
      pipe_q[0] <= stage_in;
      for (int k = 1; k < PIPE - 1; k++) begin
        pipe_q[k] <= pipe_q[k-1];
      end
      pipe_q[PIPE-1] <= stage_tail;
    end
  end

  assign bus.color_out   = pipe_q[PIPE-1].color;
  assign bus.hsync_out   = pipe_q[PIPE-1].hsync;
  assign bus.vsync_out   = pipe_q[PIPE-1].vsync;
  assign bus.von_out     = pipe_q[PIPE-1].von;
  assign bus.blink_phase = (phase_q == ON);

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Bench for vga_layer_mixer: two instances (PIPE=2 and PIPE=5) share one stimulus stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_layer_mixer;

  localparam int         BF   = 3;
  localparam logic [3:0] MASK = 4'b0101;
  localparam logic [7:0] BG   = 8'b010_010_01;
  localparam int         PA   = 2;
  localparam int         PB   = 5;

  typedef struct packed {
    logic [7:0] color;
    logic       hs;
    logic       vs;
    logic       von;
  } px_t;

  localparam px_t IDLE = '{color: 8'h00, hs: 1'b1, vs: 1'b1, von: 1'b0};

  logic        mclk = 1'b0;
  logic        rst;
  logic        hs, vs, von, tick, breq;
  logic [31:0] lc;
  logic [3:0]  lv, len;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [3:0] m_en    = 4'hF;
  int         m_ticks = 0;
  logic       m_phase = 1'b1;
  px_t        q_a[$];
  px_t        q_b[$];
  px_t        p;

  vga_layer_mixer_if #(.N_LAYERS(4), .COLOR_W(8)) bus_a ();
  vga_layer_mixer_if #(.N_LAYERS(4), .COLOR_W(8)) bus_b ();

  assign bus_a.hsync_in = hs;    assign bus_b.hsync_in = hs;
  assign bus_a.vsync_in = vs;    assign bus_b.vsync_in = vs;
  assign bus_a.von_in = von;     assign bus_b.von_in = von;
  assign bus_a.frame_tick = tick; assign bus_b.frame_tick = tick;
  assign bus_a.layer_color = lc; assign bus_b.layer_color = lc;
  assign bus_a.layer_valid = lv; assign bus_b.layer_valid = lv;
  assign bus_a.layer_en = len;   assign bus_b.layer_en = len;
  assign bus_a.blink_req = breq; assign bus_b.blink_req = breq;

  vga_layer_mixer #(.PIPE(PA), .BLINK_FRAMES(BF), .BLINK_MASK(MASK)) dut_a (
    .mclk(mclk), .reset(rst), .bus(bus_a));
  vga_layer_mixer #(.PIPE(PB), .BLINK_FRAMES(BF), .BLINK_MASK(MASK)) dut_b (
    .mclk(mclk), .reset(rst), .bus(bus_b));

  always #5 mclk = ~mclk;

  // Highest-priority visible layer, or the background.
  function automatic logic [7:0] pick(input logic [31:0] c, input logic [3:0] v,
                                      input logic [3:0] e, input logic ph);
    for (int i = 0; i < 4; i++) begin
      if (v[i] && e[i] && !(MASK[i] && !ph)) return c[i*8 +: 8];
    end
    return BG;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
    step(3);
  endtask

  task automatic rand_inputs();
    hs  = 1'($urandom);
    vs  = 1'($urandom);
    von = 1'($urandom);
    lc  = $urandom;
    lv  = 4'($urandom);
    len = 4'($urandom);
    tick = 1'($urandom);
    breq = 1'($urandom);
  endtask

  initial begin
    fork
      // reference model: one pixel per edge, blink phase from frame-tick count
      forever begin
        @(posedge mclk);
        if (rst) begin
          m_en    = 4'hF;
          m_ticks = 0;
          q_a.delete();
          q_b.delete();
          for (int k = 0; k < PA; k++) q_a.push_back(IDLE);
          for (int k = 0; k < PB; k++) q_b.push_back(IDLE);
        end else begin
          p.hs    = hs;
          p.vs    = vs;
          p.von   = von;
          p.color = von ? pick(lc, lv, m_en, m_phase) : 8'h00;
          q_a.push_back(p);
          void'(q_a.pop_front());
          q_b.push_back(p);
          void'(q_b.pop_front());
          if (tick) m_en = len;
          if (!breq) m_ticks = 0;
          else if (tick) m_ticks++;
        end
        m_phase = ((m_ticks / BF) % 2) == 0;
      end
      // per-cycle comparison of both instances against the model
      begin
        @(posedge mclk);
        forever begin
          @(negedge mclk);
          chk("cycle_a",
              32'({bus_a.color_out, bus_a.hsync_out, bus_a.vsync_out, bus_a.von_out, bus_a.blink_phase}),
              32'({q_a[0], m_phase}));
          chk("cycle_b",
              32'({bus_b.color_out, bus_b.hsync_out, bus_b.vsync_out, bus_b.von_out, bus_b.blink_phase}),
              32'({q_b[0], m_phase}));
        end
      end
    join_none

    // reset with random inputs
    rst = 1'b1;
    rand_inputs();
    step(3);
    chk("rst_color", 32'(bus_a.color_out), 32'h00);
    chk("rst_hsync", 32'(bus_a.hsync_out), 32'h1);
    chk("rst_vsync", 32'(bus_b.vsync_out), 32'h1);
    chk("rst_von", 32'(bus_b.von_out), 32'h0);
    chk("rst_phase", 32'(bus_a.blink_phase), 32'h1);
    chk("rst_model", 32'(q_b[0].color), 32'h00);

    rst = 1'b0; tick = 1'b0; breq = 1'b0; len = 4'hF; hs = 1'b0; vs = 1'b0;

    // priority: L1 beats L2
    von = 1'b1; lv = 4'b0110; lc = {8'h55, 8'h1C, 8'hE0, 8'h33};
    step(8);
    chk("prio_a", 32'(bus_a.color_out), 32'hE0);
    chk("prio_b", 32'(bus_b.color_out), 32'hE0);
    chk("prio_model", 32'(q_a[0].color), 32'hE0);

    // background and blanking
    lv = 4'b0000;
    step(8);
    chk("bg_a", 32'(bus_a.color_out), 32'h49);
    chk("bg_model", 32'(q_b[0].color), 32'h49);
    von = 1'b0; lv = 4'b1111;
    step(8);
    chk("blank_b", 32'(bus_b.color_out), 32'h00);
    chk("blank_von", 32'(bus_b.von_out), 32'h0);

    // sync alignment: hsync pulse and colour step launched together
    von = 1'b1; lv = 4'b0001; lc[7:0] = 8'h03;
    step(8);
    hs = 1'b1; lc[7:0] = 8'hFC;
    step(1);
    chk("align_a_old", 32'({bus_a.color_out, bus_a.hsync_out}), {23'h0, 8'h03, 1'b0});
    step(1);
    chk("align_a_new", 32'({bus_a.color_out, bus_a.hsync_out}), {23'h0, 8'hFC, 1'b1});
    step(2);
    chk("align_b_old", 32'({bus_b.color_out, bus_b.hsync_out}), {23'h0, 8'h03, 1'b0});
    step(1);
    chk("align_b_new", 32'({bus_b.color_out, bus_b.hsync_out}), {23'h0, 8'hFC, 1'b1});
    hs = 1'b0;

    // enable latch: clearing layer_en[0] waits for frame_tick
    lv = 4'b0011; lc[15:8] = 8'hE0;
    step(8);
    len = 4'b1110;
    step(10);
    chk("en_hold", 32'(bus_a.color_out), 32'hFC);
    tick_pulse();
    step(4);
    chk("en_applied", 32'(bus_a.color_out), 32'hE0);
    len = 4'hF;
    tick_pulse();
    step(6);
    chk("en_restore", 32'(bus_b.color_out), 32'hFC);

    // blink: BF=3, L0 masked, L1 not
    breq = 1'b1;
    step(2);
    tick_pulse(); tick_pulse();
    chk("blink_t2", 32'(bus_a.blink_phase), 32'h1);
    tick_pulse();
    chk("blink_t3", 32'(bus_a.blink_phase), 32'h0);
    chk("blink_t3_model", 32'(m_phase), 32'h0);
    step(6);
    chk("blink_off_color", 32'(bus_b.color_out), 32'hE0);
    tick_pulse(); tick_pulse();
    chk("blink_t5", 32'(bus_a.blink_phase), 32'h0);
    tick_pulse();
    chk("blink_t6", 32'(bus_a.blink_phase), 32'h1);
    step(6);
    chk("blink_on_color", 32'(bus_a.color_out), 32'hFC);
    tick_pulse(); tick_pulse(); tick_pulse();
    chk("blink_t9", 32'(bus_a.blink_phase), 32'h0);
    breq = 1'b0; tick = 1'b1;
    step(1);
    tick = 1'b0;
    chk("blink_drop", 32'(bus_a.blink_phase), 32'h1);
    step(3);
    breq = 1'b1;
    tick_pulse(); tick_pulse();
    chk("blink_cnt0", 32'(bus_a.blink_phase), 32'h1);
    tick_pulse();
    chk("blink_restart", 32'(bus_a.blink_phase), 32'h0);
    breq = 1'b0;
    step(4);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      hs  = ($urandom_range(0, 15) == 0) ? ~hs : hs;
      vs  = ($urandom_range(0, 63) == 0) ? ~vs : vs;
      von = $urandom_range(0, 3) != 0;
      lc  = $urandom;
      lv  = 4'($urandom);
      if ($urandom_range(0, 9) == 0) len = 4'($urandom);
      tick = $urandom_range(0, 19) == 0;
      if ($urandom_range(0, 99) == 0) breq = ~breq;
      rst = $urandom_range(0, 499) == 0;
      step(1);
    end
    rst = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
